// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: consumes D bits per clock through a
// registered carry, so an N-bit operation takes N/D cycles after accept.
// Results (sum/cout/overflow) are held from done until the next result lands.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one digit processed per clock, LSB digit first
//   FINISH | done pulse; a new start here restarts with no idle cycle
module digit_serial_adder #(
  parameter int N = 16,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int C  = N / D;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  // Reject digit widths that do not tile the operand exactly.
  if (D < 1 || D > N || (N % D) != 0) begin : g_bad_params
    $error("digit_serial_adder: D must lie in 1..N and divide N");
  end

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [D:0]    dsum;
  logic          msb_cin;
  logic [N-1:0]  result;
  logic          accept;

  assign accept = start && (state == IDLE || state == FINISH);

  assign dsum = {1'b0, a_sr[D-1:0]} + {1'b0, b_sr[D-1:0]} + {{D{1'b0}}, carry};

  // Carry into the digit MSB recovered from its sum bit (s = a ^ b ^ c).
  assign msb_cin = a_sr[D-1] ^ b_sr[D-1] ^ dsum[D-1];

  if (D < N) begin : g_shift
    // Holds only the digits already produced; the final digit comes
    // straight from dsum on the last edge.
    logic [N-D-1:0] part;

    assign result = {dsum[D-1:0], part};

    // Shift each new digit into the top of the partial result.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        part <= '0;
      end else if (state == RUN) begin
        part <= result[N-1:D];
      end
    end
  end else begin : g_single
    assign result = dsum[D-1:0];
  end

  // Control FSM, operand shifters, carry, digit counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> D;
        b_sr  <= b_sr >> D;
        carry <= dsum[D];
        if (cnt == LAST) begin
          sum      <= result;
          cout     <= dsum[D];
          overflow <= msb_cin ^ dsum[D];
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= FINISH;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
